usrt_regbank: RTL and testbench

- Parametrised successor to the single USRT status register: an APB-style bank of four registers (CTRL, STATUS, EVENT, IRQ_EN).
- Adds configurable wait states, error response, sticky write-1-to-clear event bits, overrun detection and an interrupt output.
- Sits between the APB bus and the USRT TX/RX cores: drives their configuration and collects their status.

---
 rtl/usrt_pkg.sv | 34 +++
 rtl/usrt_apb_slave_fsm.sv | 77 +++++++
 rtl/usrt_regbank.sv | 100 ++++++++++
 tb/tb_usrt_regbank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT register bank: register map, EVENT bit
// positions, CTRL field layout and the APB slave state encoding.
package usrt_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_EVENT  = 2'd2;
  localparam logic [1:0] ADDR_IRQEN  = 2'd3;

  localparam int unsigned EV_TX_DONE  = 0;
  localparam int unsigned EV_RX_READY = 1;
  localparam int unsigned EV_OVERRUN  = 2;
  localparam int unsigned EV_W        = 3;

  localparam int unsigned CTRL_BAUD_W = 3;
  localparam int unsigned CTRL_PAR_W  = 2;
  localparam int unsigned CTRL_W      = 8;

  // Field order gives baud in [2:0], parity in [4:3], then tx_en, rx_en, loopback.
  typedef struct packed {
    logic                   loopback;
    logic                   rx_en;
    logic                   tx_en;
    logic [CTRL_PAR_W-1:0]  parity;
    logic [CTRL_BAUD_W-1:0] baud;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

endpackage

// File: rtl/usrt_apb_slave_fsm.sv
// APB slave handshake: IDLE/SETUP/ACCESS sequencing, wait-state counter,
// transfer capture and ready/error generation for the register bank.
module usrt_apb_slave_fsm
  import usrt_pkg::*;
#(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              ready,
  output logic              slverr,
  output logic [1:0]        reg_sel,
  output logic              wr,
  output logic [7:0]        wdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e        state, state_next;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              bad_addr;
  logic              unused_wdata_hi;

  assign unused_wdata_hi = ^pwdata;
  assign reg_sel         = addr_q[1:0];
  assign bad_addr        = (32'(addr_q) >= 32'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Capture happens while in SETUP so the counter is loaded on ACCESS entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= WAIT_INIT;
      addr_q   <= paddr;
      wr       <= pwrite;
      wdata    <= pwdata[7:0];
    end else if (state == ST_ACCESS && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (psel && !penable) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (!psel || wait_cnt == '0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    slverr = 1'b0;
    if (rst_n && state == ST_ACCESS && psel && wait_cnt == '0) begin
      ready  = 1'b1;
      slverr = bad_addr || (wr && reg_sel == ADDR_STATUS);
    end
  end

endmodule

// File: rtl/usrt_regbank.sv
// USRT register bank: CTRL/STATUS/EVENT/IRQ_EN behind an APB slave, with
// sticky W1C event capture from the TX/RX cores and a registered interrupt.
module usrt_regbank
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  CTRL_RST    = 8'h00
) (
  input  logic              i_Pclk,
  input  logic              i_Reset_n,
  input  logic              i_Psel,
  input  logic              i_Penable,
  input  logic              i_Pwrite,
  input  logic [ADDR_W-1:0] i_Paddr,
  input  logic [DATA_W-1:0] i_Pwdata,
  output logic [DATA_W-1:0] o_Prdata,
  output logic              o_Pready,
  output logic              o_Pslverr,
  input  logic              i_Tx_Busy,
  input  logic              i_Rx_Full,
  output logic [CTRL_W-1:0] o_Ctrl,
  output logic              o_Irq
);

  logic            ready, slverr, wr, commit, rx_rise;
  logic [1:0]      reg_sel;
  logic [7:0]      wdata, rdata8;
  ctrl_t           ctrl;
  logic [EV_W-1:0] ev_q, ev_set, ev_clr, irq_en;
  logic            tx_busy_d, rx_full_d, irq_q;

  usrt_apb_slave_fsm #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .clk     (i_Pclk),
    .rst_n   (i_Reset_n),
    .psel    (i_Psel),
    .penable (i_Penable),
    .pwrite  (i_Pwrite),
    .paddr   (i_Paddr),
    .pwdata  (i_Pwdata),
    .ready   (ready),
    .slverr  (slverr),
    .reg_sel (reg_sel),
    .wr      (wr),
    .wdata   (wdata)
  );

  assign commit = ready && wr && !slverr;
  assign ev_clr = (commit && reg_sel == ADDR_EVENT) ? wdata[EV_W-1:0] : '0;
  assign rx_rise = !rx_full_d && i_Rx_Full;

  always_comb begin
    ev_set              = '0;
    ev_set[EV_TX_DONE]  = tx_busy_d && !i_Tx_Busy;
    ev_set[EV_RX_READY] = rx_rise;
    ev_set[EV_OVERRUN]  = rx_rise && ev_q[EV_RX_READY];
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Reset_n) begin
      ctrl      <= ctrl_t'(CTRL_RST);
      irq_en    <= '0;
      ev_q      <= '0;
      tx_busy_d <= 1'b0;
      rx_full_d <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (commit && reg_sel == ADDR_CTRL)  ctrl   <= ctrl_t'(wdata);
      if (commit && reg_sel == ADDR_IRQEN) irq_en <= wdata[EV_W-1:0];
      // Set is OR'ed after the clear so a coincident event is never lost.
      ev_q      <= (ev_q & ~ev_clr) | ev_set;
      tx_busy_d <= i_Tx_Busy;
      rx_full_d <= i_Rx_Full;
      irq_q     <= |(ev_q & irq_en);
    end
  end

  always_comb begin
    rdata8 = '0;
    case (reg_sel)
      ADDR_CTRL:   rdata8 = ctrl;
      ADDR_STATUS: rdata8 = {6'b0, i_Rx_Full, i_Tx_Busy};
      ADDR_EVENT:  rdata8 = {5'b0, ev_q};
      ADDR_IRQEN:  rdata8 = {5'b0, irq_en};
      default:     rdata8 = '0;
    endcase
  end

  assign o_Prdata  = (ready && !wr && !slverr) ? DATA_W'(rdata8) : '0;
  assign o_Pready  = ready;
  assign o_Pslverr = slverr;
  assign o_Ctrl    = ctrl;
  assign o_Irq     = irq_q;

endmodule

// File: tb/tb_usrt_regbank.sv
// Self-checking bench for usrt_regbank (DATA_W=16, ADDR_W=3, WAIT_STATES=2):
// vector table with a response scoreboard plus hand-built corner sequences.
module tb_usrt_regbank;

  localparam int unsigned WS = 2;
  localparam logic [7:0]  RST_CTRL = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n, psel, penable, pwrite, tx_busy, rx_full;
  logic [2:0]  paddr;
  logic [15:0] pwdata, prdata;
  logic        pready, pslverr, irq;
  logic [7:0]  ctrl_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        tx;
    logic        rx;
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  ctrl;
    logic        irq1;
    logic        irq2;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[24];
  exp_t sb[$];

  usrt_regbank #(
    .DATA_W      (16),
    .ADDR_W      (3),
    .WAIT_STATES (WS),
    .CTRL_RST    (RST_CTRL)
  ) dut (
    .i_Pclk    (clk),
    .i_Reset_n (rst_n),
    .i_Psel    (psel),
    .i_Penable (penable),
    .i_Pwrite  (pwrite),
    .i_Paddr   (paddr),
    .i_Pwdata  (pwdata),
    .o_Prdata  (prdata),
    .o_Pready  (pready),
    .o_Pslverr (pslverr),
    .i_Tx_Busy (tx_busy),
    .i_Rx_Full (rx_full),
    .o_Ctrl    (ctrl_o),
    .o_Irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apb(input string tag, input logic wr, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] er, input logic ee);
    exp_t e;
    int unsigned n;
    bit seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    sb.push_back('{rdata: er, err: ee});
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (pready) seen = 1;
      else if (n == 1) check({tag, "_idle_rdata"}, 32'(prdata), 32'h0);
    end
    e = sb.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready want ready within 20 cycles", tag);
    end else begin
      check({tag, "_rdata"}, 32'(prdata), 32'(e.rdata));
      check({tag, "_err"}, 32'(pslverr), 32'(e.err));
      check({tag, "_latency"}, n, 2 + WS);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic run(input string tag, input vec_t v);
    tx_busy = v.tx;
    rx_full = v.rx;
    apb(tag, v.wr, v.addr, v.wdata, v.rdata, v.err);
    @(negedge clk);
    check({tag, "_ctrl"}, 32'(ctrl_o), 32'(v.ctrl));
    check({tag, "_irq1"}, 32'(irq), 32'(v.irq1));
    @(negedge clk);
    check({tag, "_irq2"}, 32'(irq), 32'(v.irq2));
  endtask

  initial begin
    bit saw;
    //          wr    addr  wdata     tx    rx    rdata     err   ctrl   irq1  irq2
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h005A, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 16'hFF15, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0015, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 3'd3, 16'h00FC, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h15, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 3'd3, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 8'h15, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 3'd2, 16'h0004, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h15, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 3'd1, 16'h00FF, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h15, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 3'd4, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h15, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 3'd7, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h15, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 3'd3, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0015, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 3'd6, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h15, 1'b0, 1'b0};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tx_busy = 1'b0; rx_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(pready), 32'h0);
    check("rst_err", 32'(pslverr), 32'h0);
    check("rst_rdata", 32'(prdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ctrl", 32'(ctrl_o), 32'(RST_CTRL));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) run($sformatf("v%0d", i), vecs[i]);

    // TX_DONE edge lands on the commit edge of a W1C write to EVENT[0].
    tx_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 16'h0001;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (WS + 1) @(posedge clk);
    #1;
    tx_busy = 1'b0;
    @(negedge clk);
    check("coll_ready", 32'(pready), 32'h1);
    check("coll_err", 32'(pslverr), 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    run("coll_rd", '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 8'h15, 1'b0, 1'b0});

    // Reset during ACCESS of a CTRL write.
    tx_busy = 1'b0;
    rx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 16'h0077;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    saw = 0;
    @(negedge clk);
    if (pready) saw = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pready) saw = 1;
    end
    check("abort_ready", 32'(saw), 32'h0);
    check("abort_ctrl", 32'(ctrl_o), 32'(RST_CTRL));
    check("abort_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    run("post_ctrl", '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h005A, 1'b0, 8'h5A, 1'b0, 1'b0});
    run("post_event", '{1'b0, 3'd2, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h5A, 1'b0, 1'b0});
    run("post_irqen", '{1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h5A, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
